// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive control path.
package uart_rx_pkg;

    localparam int DATA_BITS  = 8;
    localparam int PRESCALE_W = 6;
    localparam int BIT_CNT_W  = 4;

    localparam logic [PRESCALE_W-1:0] PRESCALE_RST = 6'd8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        ERR_CHK = 3'd5
    } rx_state_e;

    // A frame is accepted when the stop bit is good and parity, if present, is good.
    function automatic logic frame_ok(input logic stp_err, input logic par_en, input logic par_err);
        return !stp_err && (!par_en || !par_err);
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversample (edge) and frame-bit counters; edge_cnt wraps at prescale-1 and bumps bit_cnt.
module edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  last_edge
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic                  last_edge_s;

    assign last_edge_s = (edge_cnt_q == (prescale - 6'd1));

    // Next-count logic: clear has priority over counting.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (clr) begin
            edge_cnt_d = 6'd0;
            bit_cnt_d  = 4'd0;
        end else if (en) begin
            if (last_edge_s) begin
                edge_cnt_d = 6'd0;
                bit_cnt_d  = bit_cnt_q + 4'd1;
            end else begin
                edge_cnt_d = edge_cnt_q + 6'd1;
            end
        end else begin
            edge_cnt_d = edge_cnt_q;
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_cnt_q <= 6'd0;
            bit_cnt_q  <= 4'd0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt  = edge_cnt_q;
    assign bit_cnt   = bit_cnt_q;
    assign last_edge = last_edge_s;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM. Optional frame_err output enabled by macro UART_RX_FRAME_ERR_EN.
module uart_rx_fsm
    import uart_rx_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  dat_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  deser_en,
    output logic                  data_valid
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic                  frame_err
`endif
);

    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  data_valid_q, data_valid_d;
    logic                  cnt_en_s, cnt_clr_s, last_edge_s, frame_ok_s;
    logic [PRESCALE_W-1:0] edge_cnt_s;
    logic [BIT_CNT_W-1:0]  bit_cnt_s;

    edge_bit_counter u_cnt (
        .clk       (CLK),
        .rst_n     (RST),
        .en        (cnt_en_s),
        .clr       (cnt_clr_s),
        .prescale  (prescale_q),
        .edge_cnt  (edge_cnt_s),
        .bit_cnt   (bit_cnt_s),
        .last_edge (last_edge_s)
    );

    assign frame_ok_s = frame_ok(stp_err, par_en_q, par_err);

    // Next-state, counter control and prescale/parity-enable capture.
    always_comb begin
        state_d      = state_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        data_valid_d = 1'b0;
        cnt_en_s     = 1'b0;
        cnt_clr_s    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr_s = 1'b1;
                if (!RX_IN) begin
                    state_d    = START;
                    prescale_d = Prescale;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                cnt_en_s = 1'b1;
                if (last_edge_s) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                // The start-bit checker answers in the first DATA cycle; a glitch aborts the frame.
                if (strt_glitch && (bit_cnt_s == 4'd1) && (edge_cnt_s == 6'd0)) begin
                    state_d   = IDLE;
                    cnt_clr_s = 1'b1;
                end else begin
                    cnt_en_s = 1'b1;
                    if (last_edge_s && (bit_cnt_s == BIT_CNT_W'(DATA_BITS))) begin
                        par_en_d = PAR_EN;
                        state_d  = PAR_EN ? PARITY : STOP;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            PARITY: begin
                cnt_en_s = 1'b1;
                if (last_edge_s) begin
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                cnt_en_s = 1'b1;
                if (last_edge_s) begin
                    state_d = ERR_CHK;
                end else begin
                    state_d = STOP;
                end
            end
            ERR_CHK: begin
                cnt_clr_s    = 1'b1;
                data_valid_d = frame_ok_s;
                if (!RX_IN) begin
                    state_d    = START;
                    prescale_d = Prescale;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // State, latched configuration and data_valid registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= IDLE;
            prescale_q   <= PRESCALE_RST;
            par_en_q     <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            data_valid_q <= data_valid_d;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;

    assign frame_err_d = (state_q == ERR_CHK) && !frame_ok_s;

    // Frame error pulse register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`endif

    // Strobes are decoded from registered state and counters only.
    assign dat_samp_en = (state_q != IDLE);
    assign strt_chk_en = (state_q == START)  && last_edge_s;
    assign deser_en    = (state_q == DATA)   && last_edge_s;
    assign par_chk_en  = (state_q == PARITY) && last_edge_s;
    assign stp_chk_en  = (state_q == STOP)   && last_edge_s;
    assign data_valid  = data_valid_q;
    assign edge_cnt    = edge_cnt_s;
    assign bit_cnt     = bit_cnt_s;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed testbench for uart_rx_fsm; expected counts and cycle positions are hand-derived.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST, RX_IN, PAR_EN, strt_glitch, par_err, stp_err;
    logic [5:0] Prescale;
    logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    always #5 CLK = ~CLK;

    uart_rx_fsm dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .deser_en    (deser_en),
        .data_valid  (data_valid)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err   (frame_err)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    int cnt_strt, cnt_par, cnt_stp, cnt_deser, cnt_dv, cnt_fe;
    int dv_first, dv_last, deser_first, par_first, overlap, max_edge;
    int bit_a  [0:1023];
    int edge_a [0:1023];
    int dse_a  [0:1023];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drives one or two frames starting with RX_IN low at edge 0; records per-cycle observations.
    task automatic run_frames(input int ps, input logic par, input logic [7:0] d0, input logic [7:0] d1,
                              input int nfr, input int glitch_len, input int ncyc,
                              input int ps_new_at, input int pe_flip_at,
                              input logic sg, input logic pe, input logic se);
        int fbits, s1, e, rel, bitn, k, nstb;
        logic ln;
        logic [7:0] dd;
        fbits = par ? 11 : 10;
        s1 = fbits * ps + 1;
        Prescale = 6'(ps);
        PAR_EN = par;
        strt_glitch = sg;
        par_err = pe;
        stp_err = se;
        cnt_strt = 0; cnt_par = 0; cnt_stp = 0; cnt_deser = 0; cnt_dv = 0; cnt_fe = 0;
        dv_first = -1; dv_last = -1; deser_first = -1; par_first = -1; overlap = 0; max_edge = 0;
        RX_IN = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            step();
            bit_a[c]  = int'(bit_cnt);
            edge_a[c] = int'(edge_cnt);
            dse_a[c]  = int'(dat_samp_en);
            if (strt_chk_en) cnt_strt++;
            if (stp_chk_en) cnt_stp++;
            if (par_chk_en) begin
                cnt_par++;
                if (par_first < 0) par_first = c;
            end
            if (deser_en) begin
                cnt_deser++;
                if (deser_first < 0) deser_first = c;
            end
            if (data_valid) begin
                cnt_dv++;
                if (dv_first < 0) dv_first = c;
                dv_last = c;
            end
`ifdef UART_RX_FRAME_ERR_EN
            if (frame_err) cnt_fe++;
`endif
            nstb = int'(strt_chk_en) + int'(par_chk_en) + int'(stp_chk_en) + int'(deser_en) + int'(data_valid);
            if (nstb > 1) overlap++;
            if (int'(edge_cnt) > max_edge) max_edge = int'(edge_cnt);
            if (c == ps_new_at) Prescale = (ps == 8) ? 6'd16 : 6'd8;
            if (c == pe_flip_at) PAR_EN = ~PAR_EN;
            e = c + 1;
            if (glitch_len > 0) begin
                ln = (e < glitch_len) ? 1'b0 : 1'b1;
            end else begin
                k = (nfr > 1 && e >= s1 - 1) ? 1 : 0;
                rel = e - k * s1;
                dd = (k == 1) ? d1 : d0;
                if (rel < 0) rel = 0;
                bitn = rel / ps;
                if (bitn == 0) ln = 1'b0;
                else if (bitn <= 8) ln = dd[bitn-1];
                else if (bitn == 9 && par) ln = ^dd;
                else ln = 1'b1;
            end
            RX_IN = ln;
        end
        RX_IN = 1'b1;
        step();
        step();
    endtask

    initial begin
        RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        step();
        step();
        check_eq("rst_outputs", int'({strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid, dat_samp_en}), 0);
        check_eq("rst_edge_cnt", int'(edge_cnt), 0);
        check_eq("rst_bit_cnt", int'(bit_cnt), 0);
        RST = 1'b1;
        step();
        check_eq("idle_samp_en", int'(dat_samp_en), 0);

        // Prescale 8, no parity, 0x55; Prescale input changes to 16 mid-frame.
        run_frames(8, 1'b0, 8'h55, 8'h00, 1, 0, 90, 20, -1, 1'b0, 1'b0, 1'b0);
        check_eq("p8_start_bit", bit_a[0], 0);
        check_eq("p8_start_samp", dse_a[0], 1);
        check_eq("p8_strt_cnt", cnt_strt, 1);
        check_eq("p8_deser_cnt", cnt_deser, 8);
        check_eq("p8_deser_first", deser_first, 15);
        check_eq("p8_stp_cnt", cnt_stp, 1);
        check_eq("p8_par_cnt", cnt_par, 0);
        check_eq("p8_dv_cnt", cnt_dv, 1);
        check_eq("p8_dv_cycle", dv_first, 81);
        check_eq("p8_max_edge", max_edge, 7);
        check_eq("p8_overlap", overlap, 0);
        check_eq("p8_idle_after", dse_a[89], 0);
        check_eq("p8_fe_cnt", cnt_fe, 0);

        // Prescale 16, parity present, parity error reported.
        run_frames(16, 1'b1, 8'hA3, 8'h00, 1, 0, 181, -1, -1, 1'b0, 1'b1, 1'b0);
        check_eq("p16_par_cnt", cnt_par, 1);
        check_eq("p16_par_cycle", par_first, 159);
        check_eq("p16_deser_first", deser_first, 31);
        check_eq("p16_stp_cnt", cnt_stp, 1);
        check_eq("p16_dv_cnt", cnt_dv, 0);
        check_eq("p16_max_edge", max_edge, 15);
`ifdef UART_RX_FRAME_ERR_EN
        check_eq("p16_fe_cnt", cnt_fe, 1);
`endif

        // Start glitch: line low for 3 cycles, checker flags a glitch.
        run_frames(8, 1'b0, 8'h00, 8'h00, 1, 3, 20, -1, -1, 1'b1, 1'b0, 1'b0);
        check_eq("gl_abort_bit", bit_a[8], 1);
        check_eq("gl_abort_edge", edge_a[8], 0);
        check_eq("gl_idle_samp", dse_a[9], 0);
        check_eq("gl_idle_bit", bit_a[9], 0);
        check_eq("gl_strt_cnt", cnt_strt, 1);
        check_eq("gl_deser_cnt", cnt_deser, 0);
        check_eq("gl_dv_cnt", cnt_dv, 0);

        // Two back-to-back frames at Prescale 32.
        run_frames(32, 1'b0, 8'h0F, 8'hF0, 2, 0, 647, -1, -1, 1'b0, 1'b0, 1'b0);
        check_eq("b2b_dv_cnt", cnt_dv, 2);
        check_eq("b2b_dv_first", dv_first, 321);
        check_eq("b2b_dv_last", dv_last, 642);
        check_eq("b2b_strt_cnt", cnt_strt, 2);
        check_eq("b2b_deser_cnt", cnt_deser, 16);
        check_eq("b2b_errchk_samp", dse_a[320], 1);
        check_eq("b2b_restart_samp", dse_a[321], 1);
        check_eq("b2b_restart_bit", bit_a[321], 0);
        check_eq("b2b_max_edge", max_edge, 31);
        check_eq("b2b_overlap", overlap, 0);

        // Stop-bit error suppresses data_valid.
        run_frames(8, 1'b0, 8'h3C, 8'h00, 1, 0, 90, -1, -1, 1'b0, 1'b0, 1'b1);
        check_eq("se_stp_cnt", cnt_stp, 1);
        check_eq("se_dv_cnt", cnt_dv, 0);
`ifdef UART_RX_FRAME_ERR_EN
        check_eq("se_fe_cnt", cnt_fe, 1);
`endif

        // Good parity frame.
        run_frames(8, 1'b1, 8'hC7, 8'h00, 1, 0, 95, -1, -1, 1'b0, 1'b0, 1'b0);
        check_eq("pg_par_cnt", cnt_par, 1);
        check_eq("pg_dv_cnt", cnt_dv, 1);
        check_eq("pg_dv_cycle", dv_first, 89);

        // PAR_EN dropped after DATA exit: frame still treated as having parity.
        run_frames(8, 1'b1, 8'h81, 8'h00, 1, 0, 95, -1, 75, 1'b0, 1'b1, 1'b0);
        check_eq("pf_par_cnt", cnt_par, 1);
        check_eq("pf_dv_cnt", cnt_dv, 0);

        // Reset asserted mid-DATA at bit_cnt 4.
        Prescale = 6'd8; PAR_EN = 1'b0; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        RX_IN = 1'b0;
        for (int i = 0; i < 33; i++) begin
            step();
            RX_IN = 1'b1;
        end
        check_eq("mr_bit_before", int'(bit_cnt), 4);
        check_eq("mr_samp_before", int'(dat_samp_en), 1);
        RST = 1'b0;
        step();
        check_eq("mr_outputs", int'({strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid, dat_samp_en}), 0);
        check_eq("mr_edge_cnt", int'(edge_cnt), 0);
        check_eq("mr_bit_cnt", int'(bit_cnt), 0);
        RST = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_eq("mr_stay_idle", int'(dat_samp_en), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 CLK  input  1  receiver oversampling clock; all state changes on rising edge.
REQ-002 RST  input  1  reset, synchronous, active-low.
REQ-003 RX_IN  input  1  serial line, idle high, already synchronised to CLK.
REQ-004 Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-005 PAR_EN  input  1  1 = parity bit present in frame.
REQ-006 strt_glitch / par_err / stp_err  input  1 each  registered checker results, valid the cycle after the matching enable.
REQ-007 dat_samp_en  output  1  sampler enable.
REQ-008 edge_cnt  output  6  oversample index within the current bit.
REQ-009 bit_cnt  output  4  frame bit index: 0 = start, 1..8 = data, 9 = parity or stop.
REQ-010 strt_chk_en / par_chk_en / stp_chk_en / deser_en  output  1 each  single-cycle checker and deserialiser strobes.
REQ-011 data_valid  output  1  one-cycle pulse when a frame has been accepted.

Function
REQ-012 States are IDLE, START, DATA, PARITY, STOP and ERR_CHK; the encoding is binary and registered.
REQ-013 IDLE:
- RX_IN = 0 moves the FSM to START.
- edge_cnt = 0 and bit_cnt = 0.
- Prescale is latched into an internal register on this transition; Prescale changes mid-frame are ignored.
REQ-014 In every non-IDLE state, edge_cnt increments each cycle and wraps from Pl-1 to 0, where Pl is the latched Prescale.
- bit_cnt increments on each wrap.
- dat_samp_en = 1 in every non-IDLE state.
REQ-015 START: at edge_cnt = Pl-1, strt_chk_en = 1 for one cycle and the FSM moves to DATA.
REQ-016 DATA, first cycle (bit_cnt = 1, edge_cnt = 0): strt_glitch = 1 aborts to IDLE and clears the counters; no strobes are issued.
REQ-017 DATA: deser_en = 1 at edge_cnt = Pl-1 of each data bit.
- After bit_cnt = 8 completes, the FSM moves to PARITY if PAR_EN = 1, otherwise to STOP.
REQ-018 PARITY: par_chk_en = 1 at edge_cnt = Pl-1, then the FSM moves to STOP.
REQ-019 STOP: stp_chk_en = 1 at edge_cnt = Pl-1, then the FSM moves to ERR_CHK.
REQ-020 ERR_CHK lasts one cycle.
- data_valid = 1 if stp_err = 0 and (PAR_EN = 0 or par_err = 0); otherwise data_valid = 0.
- Next state is START if RX_IN = 0 (back-to-back frame, Prescale re-latched), else IDLE.
- Counters are cleared on exit.
REQ-021 At most one of the strt/par/stp/deser strobes and data_valid is high in any cycle.
REQ-022 PAR_EN is sampled at the DATA-to-next-state transition; PAR_EN changes at any other time have no effect on the current frame.
REQ-023 All outputs are registered, or decoded only from registered state and counters; no output depends combinationally on RX_IN.

Reset
REQ-024 RST = 0 at a rising edge forces the following, regardless of state or mid-frame position:
- state = IDLE.
- edge_cnt = 0 and bit_cnt = 0.
- latched Prescale = 8.
- all strobes, dat_samp_en and data_valid = 0.
REQ-025 After release, the first frame is recognised only on a fresh RX_IN = 0 sampled in IDLE.

Configuration
REQ-026 Macro UART_RX_FRAME_ERR_EN.
- Defined: adds output frame_err (1 bit), which pulses for one cycle in ERR_CHK whenever data_valid is suppressed; it resets to 0.
- Undefined: the port and its logic are absent; errors only suppress data_valid.

Structure
REQ-027 Package uart_rx_pkg holds:
- the state typedef;
- DATA_BITS = 8;
- PRESCALE_W = 6;
- BIT_CNT_W = 4.
REQ-028 Sub-module edge_bit_counter implements edge_cnt and bit_cnt, including enable, clear and the wrap-at-Pl-1 rule. The FSM instantiates it once.

Verification
REQ-029 Prescale = 8, PAR_EN = 0, frame 0x55 with a good stop bit, all error inputs 0 -> deser_en pulses 8 times, stp_chk_en once, data_valid one cycle at 10*8+1 cycles after the start edge.
REQ-030 Prescale = 16, PAR_EN = 1, par_err = 1 in STOP -> par_chk_en pulses once, data_valid stays 0, frame_err = 1 (macro defined).
REQ-031 RX_IN low for 3 cycles only, strt_glitch = 1 returned -> FSM back to IDLE at bit_cnt = 1, edge_cnt = 0, with no deser_en pulses.
REQ-032 Two back-to-back frames at Prescale = 32 with RX_IN = 0 during ERR_CHK -> START is entered directly, and both frames give data_valid.
REQ-033 RST = 0 asserted mid-DATA (bit_cnt = 4) -> next cycle all outputs are 0 and the FSM is in IDLE. Prescale changed from 8 to 16 mid-frame -> the current frame still uses 8.
